// File: rtl/maxpool_scheduler.sv
// rtl/maxpool_scheduler.sv - 2x2 stride-2 max-pool sequencer over a word-addressed SRAM pair
module maxpool_scheduler #(
    parameter int DATA_BITS = 32,
    parameter int D         = 32,
    parameter int H         = 46,
    parameter int W         = 46,
    parameter int ADDR_BITS = 17
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [ADDR_BITS-1:0] rd_addr,
    input  logic [DATA_BITS-1:0] rd_data,
    output logic                 wr_en,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [DATA_BITS-1:0] wr_data,
    input  logic                 wr_ready
);

    localparam int CB = (D > 1) ? $clog2(D) : 1;
    localparam int RB = (H > 2) ? $clog2(H) : 1;
    localparam int XB = (W > 2) ? $clog2(W) : 1;

    // Read offsets of the four window taps relative to the window's top-left word.
    localparam logic [ADDR_BITS-1:0] OFF_ROW  = ADDR_BITS'(W);
    localparam logic [ADDR_BITS-1:0] OFF_DIAG = ADDR_BITS'(W + 1);
    // Stepping to the next window: +2 within a row pair, +W+2 when x wraps
    // (this also covers the jump into the next channel plane).
    localparam logic [ADDR_BITS-1:0] STEP_X   = ADDR_BITS'(2);
    localparam logic [ADDR_BITS-1:0] STEP_ROW = ADDR_BITS'(W + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CB-1:0]          c_q;
    logic [RB-1:0]          r_q;
    logic [XB-1:0]          x_q;
    logic [ADDR_BITS-1:0]   in_base_q;
    logic [ADDR_BITS-1:0]   out_addr_q;
    logic [DATA_BITS-1:0]   max_q;

    logic x_wrap, r_wrap, last_win, accept;

    assign x_wrap   = (x_q == XB'(W - 2));
    assign r_wrap   = (r_q == RB'(H - 2));
    assign last_win = x_wrap && r_wrap && (c_q == CB'(D - 1));
    assign accept   = (state_q == S_WRITE) && wr_ready;

    // State register; reset aborts any pass immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: fixed read/drain sequence, WRITE waits for the handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RD0;
            S_RD0:   state_d = S_RD1;
            S_RD1:   state_d = S_RD2;
            S_RD2:   state_d = S_RD3;
            S_RD3:   state_d = S_DRAIN;
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: if (wr_ready) state_d = last_win ? S_DONE : S_RD0;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; read address is only driven during reads.
    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = (state_q == S_WRITE);
        wr_addr = out_addr_q;
        wr_data = max_q;
        case (state_q)
            S_RD0: begin rd_en = 1'b1; rd_addr = in_base_q;              end
            S_RD1: begin rd_en = 1'b1; rd_addr = in_base_q + 1'b1;       end
            S_RD2: begin rd_en = 1'b1; rd_addr = in_base_q + OFF_ROW;    end
            S_RD3: begin rd_en = 1'b1; rd_addr = in_base_q + OFF_DIAG;   end
            default: ;
        endcase
    end

    // Datapath: running signed max, window counters and address bases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_q        <= '0;
            r_q        <= '0;
            x_q        <= '0;
            in_base_q  <= '0;
            out_addr_q <= '0;
            max_q      <= '0;
        end else begin
            case (state_q)
                // First tap arrives here; load it so negative windows pool correctly.
                S_RD1: max_q <= rd_data;
                S_RD2, S_RD3, S_DRAIN: begin
                    if ($signed(rd_data) > $signed(max_q)) max_q <= rd_data;
                end
                S_DONE: begin
                    c_q        <= '0;
                    r_q        <= '0;
                    x_q        <= '0;
                    in_base_q  <= '0;
                    out_addr_q <= '0;
                end
                default: ;
            endcase
            if (accept && !last_win) begin
                out_addr_q <= out_addr_q + 1'b1;
                if (x_wrap) begin
                    x_q       <= '0;
                    in_base_q <= in_base_q + STEP_ROW;
                    if (r_wrap) begin
                        r_q <= '0;
                        c_q <= c_q + 1'b1;
                    end else begin
                        r_q <= r_q + RB'(2);
                    end
                end else begin
                    x_q       <= x_q + XB'(2);
                    in_base_q <= in_base_q + STEP_X;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool_scheduler.sv
// tb/tb_maxpool_scheduler.sv - directed and table-driven checks for maxpool_scheduler
module tb_maxpool_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done, rd_en, wr_en;
    logic [5:0]  rd_addr, wr_addr;
    logic [31:0] rd_data = '0;
    logic [31:0] wr_data;
    logic        wr_ready;

    logic        start2;
    logic        busy2, done2, rd_en2, wr_en2;
    logic [7:0]  rd_addr2, wr_addr2;
    logic [31:0] rd_data2 = '0;
    logic [31:0] wr_data2;
    logic        wr_ready2;

    logic [31:0] mem1 [0:63];
    logic [31:0] mem2 [0:255];
    logic [5:0]  wlog_a [0:15];
    logic [31:0] wlog_d [0:15];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    maxpool_scheduler #(.DATA_BITS(32), .D(2), .H(4), .W(4), .ADDR_BITS(6)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
    );

    maxpool_scheduler #(.DATA_BITS(32), .D(3), .H(6), .W(8), .ADDR_BITS(8)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2), .wr_ready(wr_ready2)
    );

    // Synchronous SRAM models: data one cycle after the strobe.
    always @(posedge clk) if (rd_en)  rd_data  <= mem1[rd_addr];
    always @(posedge clk) if (rd_en2) rd_data2 <= mem2[rd_addr2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 64; i++) mem1[i] = i;
    endtask

    // One pass on dut; optional stall of write stall_idx for stall_n cycles,
    // optional start pokes while busy and during DONE.
    task automatic run1(input int stall_idx, input int stall_n, input bit poke,
                        output int done_at, output int wr_n, output int rd_n,
                        output int done_n, output int err_n, output int busy_after);
        int stalled;
        logic [5:0]  held_a;
        logic [31:0] held_d;
        done_at = -1; wr_n = 0; rd_n = 0; done_n = 0; err_n = 0; busy_after = -1;
        stalled = 0; held_a = '0; held_d = '0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (rd_en) rd_n++;
            if (rd_en && wr_en) err_n++;
            if (n == 1 && !(rd_en && busy && rd_addr == 6'd0)) err_n++;
            if (done_at > 0 && n == done_at + 1) busy_after = busy;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = n;
            end
            start = poke && (n == 10 || done);
            if (wr_en) begin
                if (stalled > 0 && wr_n == stall_idx && (wr_addr !== held_a || wr_data !== held_d))
                    err_n++;
                if (wr_n == stall_idx && stalled < stall_n) begin
                    held_a = wr_addr; held_d = wr_data;
                    wr_ready = 1'b0;
                    stalled++;
                end else begin
                    wr_ready = 1'b1;
                    if (wr_n < 16) begin
                        wlog_a[wr_n] = wr_addr;
                        wlog_d[wr_n] = wr_data;
                    end
                    wr_n++;
                end
            end else begin
                wr_ready = 1'b1;
            end
            if (done_at > 0 && n >= done_at + 4) break;
        end
        start = 1'b0;
        wr_ready = 1'b1;
        if (done_at < 0) chk("run1_timeout", 0, 1);
    endtask

    typedef struct packed {
        logic [31:0] a, b, c, d, exp;
    } nvec_t;

    nvec_t       nv [7];
    logic [31:0] exp_basic [8];
    logic [31:0] exp2 [0:35];
    logic [31:0] m;

    int done_at, wr_n, rd_n, done_n, err_n, busy_after;
    int cnt2, seen2, rd_after;

    initial begin
        nv[0] = '{a: -32'sd8,  b: -32'sd3, c: -32'sd5,        d: -32'sd100,     exp: -32'sd3};
        nv[1] = '{a: 32'd1,    b: 32'd2,   c: 32'd3,          d: 32'd4,         exp: 32'd4};
        nv[2] = '{a: 32'd9,    b: 32'd1,   c: 32'd2,          d: 32'd3,         exp: 32'd9};
        nv[3] = '{a: 32'd0,    b: 32'd6,   c: -32'sd1,        d: 32'd2,         exp: 32'd6};
        nv[4] = '{a: -32'sd1,  b: -32'sd2, c: 32'h7FFF_FFFF,  d: 32'h8000_0000, exp: 32'h7FFF_FFFF};
        nv[5] = '{a: 32'h8000_0000, b: 32'h8000_0000, c: 32'h8000_0000, d: 32'h8000_0000,
                  exp: 32'h8000_0000};
        nv[6] = '{a: 32'd5,    b: 32'd5,   c: 32'd5,          d: 32'd5,         exp: 32'd5};
        exp_basic = '{32'd5, 32'd7, 32'd13, 32'd15, 32'd21, 32'd23, 32'd29, 32'd31};

        reset = 1'b1; start = 1'b0; wr_ready = 1'b1; start2 = 1'b0; wr_ready2 = 1'b1;
        load_ramp();
        #1;
        chk("reset_outputs", {busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data},
            {3'b000, 6'd0, 1'b0, 6'd0, 32'd0});
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Basic pass with ramp data.
        run1(-1, 0, 1'b0, done_at, wr_n, rd_n, done_n, err_n, busy_after);
        chk("basic_done_cycle", done_at, 49);
        chk("basic_writes", wr_n, 8);
        chk("basic_reads", rd_n, 32);
        chk("basic_done_pulses", done_n, 1);
        chk("basic_protocol", err_n, 0);
        chk("basic_busy_after", busy_after, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("basic_addr%0d", i), wlog_a[i], i);
            chk($sformatf("basic_data%0d", i), wlog_d[i], exp_basic[i]);
        end

        // Window-value table applied to the first window.
        for (int k = 0; k < 7; k++) begin
            load_ramp();
            mem1[0] = nv[k].a; mem1[1] = nv[k].b; mem1[4] = nv[k].c; mem1[5] = nv[k].d;
            run1(-1, 0, 1'b0, done_at, wr_n, rd_n, done_n, err_n, busy_after);
            chk($sformatf("win%0d_max", k), wlog_d[0], nv[k].exp);
            chk($sformatf("win%0d_next", k), wlog_d[1], 32'd7);
        end
        load_ramp();

        // Backpressure on the second write.
        run1(1, 3, 1'b0, done_at, wr_n, rd_n, done_n, err_n, busy_after);
        chk("bp_done_cycle", done_at, 52);
        chk("bp_reads", rd_n, 32);
        chk("bp_hold", err_n, 0);
        chk("bp_addr1", wlog_a[1], 6'd1);
        chk("bp_data1", wlog_d[1], 32'd7);
        chk("bp_writes", wr_n, 8);

        // Start pokes while busy and during DONE.
        run1(-1, 0, 1'b1, done_at, wr_n, rd_n, done_n, err_n, busy_after);
        chk("poke_done_pulses", done_n, 1);
        chk("poke_writes", wr_n, 8);
        chk("poke_busy_after", busy_after, 0);
        chk("poke_reads", rd_n, 32);

        // Reset during RD2 of window 3 (c0, r2, x2: base 10, tap row+1 -> 14).
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (21) @(negedge clk);
        chk("rst_pre_rd", {rd_en, rd_addr}, {1'b1, 6'd14});
        reset = 1'b1;
        #1;
        chk("rst_abort", {rd_en, wr_en, busy, done}, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        rd_after = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (rd_en || wr_en || busy || done) rd_after++;
        end
        chk("rst_stays_idle", rd_after, 0);
        run1(-1, 0, 1'b0, done_at, wr_n, rd_n, done_n, err_n, busy_after);
        chk("rst_rerun_done", done_at, 49);
        chk("rst_rerun_addr0", wlog_a[0], 6'd0);
        chk("rst_rerun_data0", wlog_d[0], 32'd5);
        chk("rst_rerun_data7", wlog_d[7], 32'd31);

        // Larger geometry with random data and random backpressure.
        for (int i = 0; i < 256; i++) mem2[i] = $urandom;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 6; r += 2)
                for (int x = 0; x < 8; x += 2) begin
                    m = mem2[c*48 + r*8 + x];
                    if ($signed(mem2[c*48 + r*8 + x + 1]) > $signed(m)) m = mem2[c*48 + r*8 + x + 1];
                    if ($signed(mem2[c*48 + (r+1)*8 + x]) > $signed(m)) m = mem2[c*48 + (r+1)*8 + x];
                    if ($signed(mem2[c*48 + (r+1)*8 + x + 1]) > $signed(m)) m = mem2[c*48 + (r+1)*8 + x + 1];
                    exp2[c*12 + (r/2)*4 + x/2] = m;
                end
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        cnt2 = 0; seen2 = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (done2) begin seen2 = 1; break; end
            wr_ready2 = ($urandom_range(0, 3) != 0);
            if (wr_en2 && wr_ready2) begin
                chk($sformatf("big_addr%0d", cnt2), wr_addr2, cnt2);
                chk($sformatf("big_data%0d", cnt2), wr_data2, exp2[cnt2 % 36]);
                cnt2++;
            end
        end
        wr_ready2 = 1'b1;
        chk("big_done_seen", seen2, 1);
        chk("big_writes", cnt2, 36);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
